// File: rtl/hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage pipeline: operand forwarding, load-use and
// branch-operand stalls, taken-branch flush, and the multi-cycle mult/div busy sequencer.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [4:0] Rs_D,
  input  logic [4:0] Rt_D,
  input  logic       UsesRs_D,
  input  logic       UsesRt_D,
  input  logic       Branch_D,
  input  logic       PCSrc_D,
  input  logic       MduStart_D,
  input  logic       MduDiv_D,
  input  logic       UsesHiLo_D,
  input  logic [4:0] Rs_E,
  input  logic [4:0] Rt_E,
  input  logic [4:0] RegAddr3_E,
  input  logic [4:0] RegAddr3_M,
  input  logic [4:0] RegAddr3_W,
  input  logic       RegWriteEN_E,
  input  logic       RegWriteEN_M,
  input  logic       RegWriteEN_W,
  input  logic       MemRead_E,
  input  logic       MemRead_M,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       MduBusy,
  output logic       MduDone
);

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  localparam logic [7:0] MUL_LOAD = 8'(MUL_LAT - 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_LAT - 1);

  mdu_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic       lw_stall;
  logic       br_stall;
  logic       mdu_stall;
  logic       stall;
  logic       ex_hit_d;
  logic       mem_hit_d;
  logic       mdu_accept;
  logic       mdu_busy;
  logic       mdu_done;
  logic [1:0] fwd_ae;
  logic [1:0] fwd_be;
  logic       fwd_ad;
  logic       fwd_bd;

  // $0 is hardwired, so a write to it can never create a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] ex_fwd_sel(input logic [4:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (RegWriteEN_M && reg_match(RegAddr3_M, src)) begin
      sel = 2'b10;
    end else if (RegWriteEN_W && reg_match(RegAddr3_W, src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_ae = ex_fwd_sel(Rs_E);
    fwd_be = ex_fwd_sel(Rt_E);
    // A load in MEM has no result on ALUOut_M yet; that case is covered by br_stall.
    fwd_ad = RegWriteEN_M & reg_match(RegAddr3_M, Rs_D) & ~MemRead_M;
    fwd_bd = RegWriteEN_M & reg_match(RegAddr3_M, Rt_D) & ~MemRead_M;
  end

  always_comb begin
    ex_hit_d  = (UsesRs_D & reg_match(RegAddr3_E, Rs_D)) |
                (UsesRt_D & reg_match(RegAddr3_E, Rt_D));
    mem_hit_d = (UsesRs_D & reg_match(RegAddr3_M, Rs_D)) |
                (UsesRt_D & reg_match(RegAddr3_M, Rt_D));
    lw_stall  = MemRead_E & ex_hit_d;
    br_stall  = Branch_D & ((RegWriteEN_E & ex_hit_d) | (MemRead_M & mem_hit_d));
    mdu_stall = (UsesHiLo_D | MduStart_D) & (state_q == MDU_BUSY);
    stall     = lw_stall | br_stall | mdu_stall;
  end

  // A start held in ID behind any stall is simply retried once the stall clears.
  assign mdu_accept = MduStart_D & ~stall;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mdu_busy = 1'b0;
    mdu_done = 1'b0;
    unique case (state_q)
      MDU_IDLE: begin
        if (mdu_accept) begin
          state_d = MDU_BUSY;
          cnt_d   = MduDiv_D ? DIV_LOAD : MUL_LOAD;
        end
      end
      MDU_BUSY: begin
        mdu_busy = 1'b1;
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = MDU_DONE;
        end
      end
      MDU_DONE: begin
        mdu_done = 1'b1;
        if (mdu_accept) begin
          state_d = MDU_BUSY;
          cnt_d   = MduDiv_D ? DIV_LOAD : MUL_LOAD;
        end else begin
          state_d = MDU_IDLE;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= MDU_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by RESET so they drop immediately, not at the next edge.
  always_comb begin
    StallF    = RESET & stall;
    StallD    = RESET & stall;
    FlushE    = RESET & stall;
    FlushD    = RESET & PCSrc_D & ~stall;
    ForwardAE = RESET ? fwd_ae : 2'b00;
    ForwardBE = RESET ? fwd_be : 2'b00;
    ForwardAD = RESET & fwd_ad;
    ForwardBD = RESET & fwd_bd;
    MduBusy   = RESET & mdu_busy;
    MduDone   = RESET & mdu_done;
  end

endmodule
